alu_exec_ctrl: RTL and testbench

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

---
 rtl/alu_exec_ctrl_if.sv | 39 +++
 rtl/alu_exec_ctrl.sv | 101 ++++++++++
 tb/tb_alu_exec_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_ctrl_if.sv
// Instruction, register-bank and ALU signals of alu_exec_ctrl.
// slave  : the controller side.
// master : the environment side (requester, register bank, ALU).
interface alu_exec_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [4:0]  instr_rs1;
  logic [4:0]  instr_rs2;
  logic [4:0]  instr_rd;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_r;
  logic        busy;
  logic        done;
  logic [15:0] retired_cnt;

  modport slave (
    input  instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd,
    input  rf_rdata1, rf_rdata2, alu_r,
    output instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
    output alu_a, alu_b, alu_op, busy, done, retired_cnt
  );

  modport master (
    output instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd,
    output rf_rdata1, rf_rdata2, alu_r,
    input  instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
    input  alu_a, alu_b, alu_op, busy, done, retired_cnt
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// ALU execution controller: accept -> READ -> EXEC -> WB, one instruction
// per four cycles. Register bank and ALU are external and combinational.
// Optional macro R0_ZERO_EN: register 0 reads as zero and is never written.
module alu_exec_ctrl (
  input  logic            clk,
  input  logic            rst,
  alu_exec_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [31:0] opa_q, opb_q, res_q;
  logic [15:0] cnt_q;
  logic        accept;
  logic [31:0] opa_d, opb_d;
  logic        wr_en;

  assign accept = (state == IDLE) && bus.instr_valid;

`ifdef R0_ZERO_EN
  assign opa_d = (rs1_q == 5'd0) ? 32'd0 : bus.rf_rdata1;
  assign opb_d = (rs2_q == 5'd0) ? 32'd0 : bus.rf_rdata2;
  assign wr_en = (rd_q != 5'd0);
`else
  assign opa_d = bus.rf_rdata1;
  assign opb_d = bus.rf_rdata2;
  assign wr_en = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: only IDLE waits, every other state advances unconditionally.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.instr_valid) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the instruction fields on acceptance; inputs are ignored afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
    end else if (accept) begin
      op_q  <= bus.instr_op;
      rs1_q <= bus.instr_rs1;
      rs2_q <= bus.instr_rs2;
      rd_q  <= bus.instr_rd;
    end
  end

  // Capture operands in READ, so rs==rd sees the pre-instruction value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (state == READ) begin
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

  // Capture the ALU result in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                res_q <= '0;
    else if (state == EXEC) res_q <= bus.alu_r;
  end

  // Retired counter; wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt_q <= '0;
    else if (state == WB) cnt_q <= cnt_q + 16'd1;
  end

  // Outputs decode straight from state, so reset clears them immediately.
  assign bus.instr_ready = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == WB);
  assign bus.rf_we       = (state == WB) && wr_en;
  assign bus.rf_waddr    = rd_q;
  assign bus.rf_wdata    = res_q;
  assign bus.rf_raddr1   = rs1_q;
  assign bus.rf_raddr2   = rs2_q;
  assign bus.alu_a       = opa_q;
  assign bus.alu_b       = opb_q;
  assign bus.alu_op      = op_q;
  assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural register bank and ALU.
module tb_alu_exec_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] rf [32];
  logic [15:0] exp_cnt;
  int   n_rdy, n_done;

  alu_exec_ctrl_if bus();

  alu_exec_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Combinational register bank.
  assign bus.rf_rdata1 = rf[bus.rf_raddr1];
  assign bus.rf_rdata2 = rf[bus.rf_raddr2];
  always @(posedge clk) if (bus.rf_we) rf[bus.rf_waddr] = bus.rf_wdata;

  // Combinational ALU.
  always_comb begin
    bus.alu_r = 32'd0;
    case (bus.alu_op)
      4'd0:  bus.alu_r = bus.alu_a + bus.alu_b;
      4'd1:  bus.alu_r = bus.alu_a - bus.alu_b;
      4'd2:  bus.alu_r = bus.alu_a * bus.alu_b;
      4'd3:  bus.alu_r = (bus.alu_b == 0) ? 32'hFFFF_FFFF : bus.alu_a / bus.alu_b;
      4'd4:  bus.alu_r = bus.alu_a & bus.alu_b;
      4'd5:  bus.alu_r = bus.alu_a | bus.alu_b;
      4'd6:  bus.alu_r = bus.alu_a ^ bus.alu_b;
      4'd7:  bus.alu_r = ~bus.alu_a;
      4'd8:  bus.alu_r = bus.alu_a;
      4'd9:  bus.alu_r = bus.alu_b;
      4'd10: bus.alu_r = bus.alu_a << bus.alu_b[4:0];
      4'd11: bus.alu_r = bus.alu_a >> bus.alu_b[4:0];
      4'd12: bus.alu_r = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      4'd13: bus.alu_r = bus.alu_a + 32'd1;
      4'd14: bus.alu_r = bus.alu_a - 32'd1;
      4'd15: bus.alu_r = 32'($countones(bus.alu_a ^ bus.alu_b));
      default: bus.alu_r = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single cycle, then scramble the inputs.
  // Returns at the negedge inside the WB cycle.
  task automatic issue(input logic [3:0] op, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d);
    @(negedge clk);
    chk("ready_idle", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr_op = op; bus.instr_rs1 = s1; bus.instr_rs2 = s2; bus.instr_rd = d;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr_op = ~op; bus.instr_rs1 = 5'd31; bus.instr_rs2 = 5'd31; bus.instr_rd = 5'd31;
    chk("read_busy", {30'd0, bus.busy, bus.instr_ready}, 32'b10);
    chk("read_raddr", {22'd0, bus.rf_raddr1, bus.rf_raddr2}, {22'd0, s1, s2});
    @(negedge clk);
    chk("exec_we_done", {30'd0, bus.rf_we, bus.done}, 32'd0);
    chk("exec_alu_op", {28'd0, bus.alu_op}, {28'd0, op});
    @(negedge clk);
  endtask

  task automatic wb_chk(input string tag, input logic we, input logic [4:0] d,
                        input logic [31:0] wdata);
    chk({tag, "_we"}, {31'd0, bus.rf_we}, {31'd0, we});
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_waddr"}, {27'd0, bus.rf_waddr}, {27'd0, d});
    chk({tag, "_wdata"}, bus.rf_wdata, wdata);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_0000 + i;
    bus.instr_valid = 1'b0;
    bus.instr_op = '0; bus.instr_rs1 = '0; bus.instr_rs2 = '0; bus.instr_rd = '0;
    exp_cnt = 16'd0;

    // Reset state.
    #12;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_we_done", {30'd0, bus.rf_we, bus.done}, 32'd0);
    chk("rst_cnt", {16'd0, bus.retired_cnt}, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    @(negedge clk); rst = 1'b0;
    chk("ready_after_rst", {31'd0, bus.instr_ready}, 32'd1);

    // add r3 = r1 + r2
    rf[1] = 32'd5; rf[2] = 32'd7;
    issue(4'd0, 5'd1, 5'd2, 5'd3);
    wb_chk("add", 1'b1, 5'd3, 32'd12);
    exp_cnt++;
    @(negedge clk);
    chk("add_cnt", {16'd0, bus.retired_cnt}, {16'd0, exp_cnt});
    chk("add_bank", rf[3], 32'd12);
    chk("idle_alu_a_hold", bus.alu_a, 32'd5);
    chk("idle_we", {31'd0, bus.rf_we}, 32'd0);

    // sra in place: reads must see the old r4
    rf[4] = 32'h8000_0000; rf[5] = 32'd4;
    issue(4'd12, 5'd4, 5'd5, 5'd4);
    wb_chk("sra", 1'b1, 5'd4, 32'hF800_0000);
    exp_cnt++;
    @(negedge clk);
    chk("sra_bank", rf[4], 32'hF800_0000);

    // sub and hamming
    issue(4'd1, 5'd2, 5'd1, 5'd6);
    wb_chk("sub", 1'b1, 5'd6, 32'd2);
    exp_cnt++;
    issue(4'd15, 5'd1, 5'd2, 5'd8);
    wb_chk("ham", 1'b1, 5'd8, 32'd1);
    exp_cnt++;
    @(negedge clk);
    chk("cnt_after4", {16'd0, bus.retired_cnt}, {16'd0, exp_cnt});

    // Back-to-back with valid held high: ready every 4th cycle, 4 done pulses.
    bus.instr_valid = 1'b1;
    bus.instr_op = 4'd13; bus.instr_rs1 = 5'd1; bus.instr_rs2 = 5'd2; bus.instr_rd = 5'd9;
    n_rdy = 0; n_done = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.instr_ready) n_rdy++;
      if (bus.done) n_done++;
      if (i == 4 || i == 5) chk("b2b_ready_pattern", {31'd0, bus.instr_ready}, (i == 4) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    exp_cnt += 16'd4;
    chk("b2b_ready_cnt", n_rdy, 32'd4);
    chk("b2b_done_cnt", n_done, 32'd4);
    chk("b2b_retired", {16'd0, bus.retired_cnt}, {16'd0, exp_cnt});
    chk("b2b_bank", rf[9], 32'd6);

    // Reset during EXEC aborts the instruction.
    rf[10] = 32'hAAAA_5555;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_op = 4'd1; bus.instr_rs1 = 5'd1; bus.instr_rs2 = 5'd2; bus.instr_rd = 5'd10;
    @(negedge clk); bus.instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_cnt", {16'd0, bus.retired_cnt}, 32'd0);
    n_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rf_we || bus.done) n_rdy++;
    end
    rst = 1'b0;
    chk("abort_no_we", n_rdy, 32'd0);
    chk("abort_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("abort_bank", rf[10], 32'hAAAA_5555);

    // Reset during WB: no write at the WB edge.
    issue(4'd9, 5'd1, 5'd2, 5'd10);
    rst = 1'b1;
    #1;
    chk("wb_abort_we_done", {30'd0, bus.rf_we, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("wb_abort_bank", rf[10], 32'hAAAA_5555);
    chk("wb_abort_cnt", {16'd0, bus.retired_cnt}, 32'd0);

    // Register 0 handling.
    rf[0] = 32'h1234;
    issue(4'd8, 5'd0, 5'd0, 5'd0);
`ifdef R0_ZERO_EN
    wb_chk("r0", 1'b0, 5'd0, 32'd0);
`else
    wb_chk("r0", 1'b1, 5'd0, 32'h1234);
`endif
    @(negedge clk);
    chk("r0_cnt", {16'd0, bus.retired_cnt}, 32'd1);

    // Counter wrap: deposit 0xFFFE in the counter rather than retiring
    // 65534 instructions, then retire two more.
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    #1;
    chk("wrap_preload", {16'd0, bus.retired_cnt}, 32'h0000_FFFE);
    issue(4'd0, 5'd1, 5'd2, 5'd11);
    @(negedge clk);
    chk("wrap_ffff", {16'd0, bus.retired_cnt}, 32'h0000_FFFF);
    issue(4'd0, 5'd1, 5'd2, 5'd11);
    @(negedge clk);
    chk("wrap_zero", {16'd0, bus.retired_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
